// File: rtl/lzc32_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lzc32_ctrl (with helper lzd8b)
// Description : Multi-cycle leading-zero counter that scans a word MSB byte
//               first through one shared 8-bit leading-zero detector.
// Revision    : 1.0 - initial release
// ============================================================================

// 8-bit leading-zero detector: z8 = 0..8, 8 when the byte is all zeros.
module lzd8b (
   input  logic [7:0] i8,
   output logic [3:0] z8
);

   always_comb begin
      z8 = 4'd8;
      // Ascending scan: the highest set bit is the last one to assign.
      for (int i = 0; i < 8; i++) begin
         if (i8[i]) begin
            z8 = 4'(7 - i);
         end
      end
   end

endmodule

module lzc32_ctrl #(
   parameter int NBYTES = 4,
   parameter int CW     = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [8*NBYTES-1:0] din,
   output logic                busy,
   output logic                done,
   output logic [CW-1:0]       zcount,
   output logic                zero_flag
);

   localparam int                 C_IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [8*NBYTES-1:0] r_word;
   logic [C_IDX_W-1:0]  r_idx;
   logic [CW-1:0]       r_acc;
   logic [CW-1:0]       r_zcount;
   logic                r_zero_flag;

   logic [7:0]          w_bytes [NBYTES];
   logic [7:0]          w_i8;
   logic [3:0]          w_z8;
   logic [CW-1:0]       w_sum;
   logic                w_byte_zero;
   logic                w_last_byte;
   logic                w_finish;

   generate
      for (genvar b = 0; b < NBYTES; b++) begin : g_bytes
         assign w_bytes[b] = r_word[8*b +: 8];
      end
   endgenerate

   assign w_i8 = w_bytes[r_idx];

   lzd8b u_lzd8b (
      .i8 (w_i8),
      .z8 (w_z8)
   );

   assign w_sum       = r_acc + CW'(w_z8);
   assign w_byte_zero = (w_z8 == 4'd8);
   assign w_last_byte = (r_idx == '0);
   // The scan ends at the first non-zero byte or after the LSB byte.
   assign w_finish    = !w_byte_zero || w_last_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_SCAN;
            end
         end
         S_SCAN: begin
            busy = 1'b1;
            if (w_finish) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word      <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_zcount    <= '0;
         r_zero_flag <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_word <= din;
                  r_idx  <= C_IDX_LAST;
                  r_acc  <= '0;
               end
            end
            S_SCAN: begin
               if (w_finish) begin
                  // Only an all-zero LSB byte can finish with a zero byte.
                  r_zcount    <= w_sum;
                  r_zero_flag <= w_byte_zero;
               end else begin
                  r_acc <= w_sum;
                  r_idx <= r_idx - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign zcount    = r_zcount;
   assign zero_flag = r_zero_flag;

endmodule

`default_nettype wire
